// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver and transmitter.
// Contents:
//   state_t    - receiver state encoding
//   PAR_*      - parity-mode values for the P parameter
//   DATA_BITS  - payload bits per frame
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

  localparam int PAR_NONE  = 0;
  localparam int PAR_EVEN  = 1;
  localparam int PAR_ODD   = 2;

  localparam int DATA_BITS = 8;

endpackage

// File: rtl/uart_baud_cnt.sv
// Per-bit clock counter for the UART receiver.
// Ports:
//   clk, reset  - system clock, asynchronous active-high reset
//   clear       - restart counting from zero on the next edge
//   half_tick   - counter is at the middle of a bit (TIMER/2-1)
//   full_tick   - counter is at the end of a bit period (TIMER-1)
module uart_baud_cnt #(
  parameter int TIMER = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic half_tick,
  output logic full_tick
);

  localparam int CW = (TIMER > 1) ? $clog2(TIMER) : 1;

  logic [CW-1:0] cnt;

  // Free-running between clears; wrapping while idle is harmless because
  // every state that uses a tick is entered with a clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      cnt <= '0;
    else if (clear) cnt <= '0;
    else            cnt <= cnt + CW'(1);
  end

  assign half_tick = (cnt == CW'(TIMER/2 - 1));
  assign full_tick = (cnt == CW'(TIMER - 1));

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receiver: 1 start bit, 8 data bits LSB first, optional parity,
// 1 stop bit. The line is sampled at mid-bit.
// Parameters:
//   TIMER - clock cycles per bit (>= 4)
//   P     - parity mode: 0 none, 1 even, 2 odd
// Ports:
//   clk, reset  - system clock, asynchronous active-high reset
//   rx          - serial line, idle high, asynchronous to clk
//   data_rx     - last received byte
//   rx_done     - one-cycle strobe when data_rx and flags update
//   parity_err  - parity mismatch on the last frame
//   frame_err   - stop bit sampled low on the last frame
//   busy        - receiver is anywhere other than IDLE
module uart_rx_fsm
  import uart_pkg::*;
#(
  parameter int TIMER = 10,
  parameter int P     = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_rx,
  output logic       rx_done,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int BW = $clog2(DATA_BITS);

  state_t                 state, state_nxt;
  logic                   rx_m, rx_s;
  logic                   half_tick, full_tick, cnt_clr;
  logic                   start_smp, data_smp, par_smp, stop_smp;
  logic [BW-1:0]          bit_idx;
  logic [DATA_BITS-1:0]   shift;
  logic                   par_err_hold;

  // Expected parity bit for a given payload under the configured mode.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
    return (P == PAR_EVEN) ? (^d) : ~(^d);
  endfunction

  // Two-flop synchronizer; resets to the idle line level so reset release
  // never looks like a start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  uart_baud_cnt #(.TIMER(TIMER)) u_baud_cnt (
    .clk       (clk),
    .reset     (reset),
    .clear     (cnt_clr),
    .half_tick (half_tick),
    .full_tick (full_tick)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (!rx_s) state_nxt = START;
      START:  if (half_tick) state_nxt = rx_s ? IDLE : DATA;
      DATA:   if (full_tick && (bit_idx == BW'(DATA_BITS - 1)))
                state_nxt = (P != PAR_NONE) ? PARITY : STOP;
      PARITY: if (full_tick) state_nxt = STOP;
      STOP:   if (full_tick) state_nxt = rx_s ? IDLE : BREAK;
      BREAK:  if (rx_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    start_smp = (state == START)  && half_tick;
    data_smp  = (state == DATA)   && full_tick;
    par_smp   = (state == PARITY) && full_tick;
    stop_smp  = (state == STOP)   && full_tick;
    cnt_clr   = (state_nxt != state) || start_smp || data_smp ||
                par_smp || stop_smp;
    busy      = (state != IDLE);
  end

  // Payload shift register: new bit enters at the MSB so the LSB-first
  // stream lands in natural bit order after eight shifts.
  always_ff @(posedge clk) begin
    if (data_smp) shift <= {rx_s, shift[DATA_BITS-1:1]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_idx      <= '0;
      par_err_hold <= 1'b0;
    end else begin
      if (start_smp) begin
        bit_idx      <= '0;
        par_err_hold <= 1'b0;
      end else if (data_smp) begin
        bit_idx <= bit_idx + BW'(1);
      end
      if (par_smp) par_err_hold <= (rx_s != parity_bit(shift));
    end
  end

  // Frame results update only on the stop-bit sample and hold otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_rx    <= 8'h00;
      rx_done    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_done <= stop_smp;
      if (stop_smp) begin
        data_rx    <= shift;
        parity_err <= par_err_hold;
        frame_err  <= ~rx_s;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: three receivers (P = 0, 1, 2) on separate lines.
// Every frame sent is queued with the result expected from the frame
// definition; a monitor matches each rx_done strobe against that queue.
module tb_uart_rx_fsm;

  localparam int TIMER = 10;

  typedef struct {
    int         idx;
    logic [7:0] data;
    logic       pe;
    logic       fe;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       rx         [3];
  logic [7:0] data_rx    [3];
  logic       rx_done    [3];
  logic       parity_err [3];
  logic       frame_err  [3];
  logic       busy       [3];

  int   total;
  int   bad;
  int   done_cnt [3];
  int   sent_cnt [3];
  exp_t exp_q [$];
  logic [7:0] last_data [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    uart_rx_fsm #(.TIMER(TIMER), .P(g)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .rx         (rx[g]),
      .data_rx    (data_rx[g]),
      .rx_done    (rx_done[g]),
      .parity_err (parity_err[g]),
      .frame_err  (frame_err[g]),
      .busy       (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Match every strobe against the oldest outstanding frame.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rx_done[i] === 1'b1) begin
        exp_t e;
        done_cnt[i]++;
        if (exp_q.size() == 0) begin
          chk($sformatf("unexpected_done_%0d", i), 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("done_instance", i, e.idx);
          chk($sformatf("data_rx_%0d", i), data_rx[i], e.data);
          chk($sformatf("parity_err_%0d", i), parity_err[i], e.pe);
          chk($sformatf("frame_err_%0d", i), frame_err[i], e.fe);
          last_data[i] = e.data;
        end
      end
    end
  end

  task automatic drive_bit(input int idx, input logic v);
    rx[idx] = v;
    repeat (TIMER) @(negedge clk);
  endtask

  // Sends one frame on line idx (parity bit only for idx 1/2) and leaves the
  // line at the stop-bit level.
  task automatic send_frame(input int idx, input logic [7:0] b,
                            input logic parbit, input logic stop);
    exp_t e;
    logic even;
    even   = ^b;
    e.idx  = idx;
    e.data = b;
    e.fe   = ~stop;
    if (idx == 0)      e.pe = 1'b0;
    else if (idx == 1) e.pe = (parbit != even);
    else               e.pe = (parbit != ~even);
    exp_q.push_back(e);
    sent_cnt[idx]++;
    drive_bit(idx, 1'b0);
    for (int k = 0; k < 8; k++) drive_bit(idx, b[k]);
    if (idx != 0) drive_bit(idx, parbit);
    drive_bit(idx, stop);
  endtask

  task automatic idle(input int idx, input int n);
    rx[idx] = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic settle(input string tag, input int idx);
    chk({tag, "_pending"}, exp_q.size(), 0);
    chk({tag, "_done_count"}, done_cnt[idx], sent_cnt[idx]);
  endtask

  initial begin
    logic [7:0] b;
    logic       pb;
    total = 0;
    bad   = 0;
    for (int i = 0; i < 3; i++) begin
      done_cnt[i]  = 0;
      sent_cnt[i]  = 0;
      last_data[i] = 8'h00;
      rx[i]        = 1'b1;
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      chk("rst_data_rx", data_rx[i], 8'h00);
      chk("rst_rx_done", rx_done[i], 1'b0);
      chk("rst_parity_err", parity_err[i], 1'b0);
      chk("rst_frame_err", frame_err[i], 1'b0);
      chk("rst_busy", busy[i], 1'b0);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Basic frame
    send_frame(0, 8'h55, 1'b0, 1'b1);
    idle(0, 2 * TIMER);
    settle("basic", 0);
    chk("basic_busy_idle", busy[0], 1'b0);

    // Back-to-back frames, directed then random
    send_frame(0, 8'hA3, 1'b0, 1'b1);
    send_frame(0, 8'h0F, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) send_frame(0, 8'($urandom), 1'b0, 1'b1);
    idle(0, 2 * TIMER);
    settle("b2b", 0);

    // Parity: even good, even bad, odd good
    send_frame(1, 8'h07, 1'b1, 1'b1);
    idle(1, 2 * TIMER);
    send_frame(1, 8'h07, 1'b0, 1'b1);
    idle(1, 2 * TIMER);
    chk("par_hold_err", parity_err[1], 1'b1);
    chk("par_hold_data", data_rx[1], 8'h07);
    send_frame(2, 8'h07, 1'b0, 1'b1);
    idle(2, 2 * TIMER);
    for (int k = 0; k < 4; k++) begin
      b  = 8'($urandom);
      pb = 1'($urandom);
      send_frame(1, b, pb, 1'b1);
      b  = 8'($urandom);
      pb = 1'($urandom);
      send_frame(2, b, pb, 1'b1);
    end
    idle(1, 2 * TIMER);
    idle(2, 2 * TIMER);
    settle("par_even", 1);
    settle("par_odd", 2);

    // Glitch on idle line
    rx[0] = 1'b0;
    repeat (3) @(negedge clk);
    idle(0, 3 * TIMER);
    settle("glitch", 0);
    chk("glitch_busy", busy[0], 1'b0);
    chk("glitch_data_hold", data_rx[0], last_data[0]);
    chk("glitch_fe_hold", frame_err[0], 1'b0);

    // Framing error with line held low afterwards
    send_frame(0, 8'h3C, 1'b0, 1'b0);
    repeat (30) @(negedge clk);
    chk("break_busy", busy[0], 1'b1);
    chk("break_fe", frame_err[0], 1'b1);
    idle(0, 4);
    chk("break_exit_busy", busy[0], 1'b0);
    settle("break", 0);
    send_frame(0, 8'h96, 1'b0, 1'b1);
    idle(0, 2 * TIMER);
    settle("after_break", 0);
    chk("after_break_fe", frame_err[0], 1'b0);

    // Reset during the 4th data bit
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    rx[0] = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_reset_busy", busy[0], 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("async_data_rx", data_rx[0], 8'h00);
    chk("async_rx_done", rx_done[0], 1'b0);
    chk("async_parity_err", parity_err[0], 1'b0);
    chk("async_frame_err", frame_err[0], 1'b0);
    chk("async_busy", busy[0], 1'b0);
    rx[0] = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle(0, 3 * TIMER);
    settle("reset_abort", 0);
    send_frame(0, 8'hC9, 1'b0, 1'b1);
    idle(0, 2 * TIMER);
    settle("post_reset", 0);
    chk("post_reset_data", data_rx[0], 8'hC9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
